mob_line_fetch: RTL

Motion-object line fetcher sitting directly downstream of the working RAM's video-phase read port. Once per scanline it walks the active motion-object buffer, reads each object's 4-byte descriptor, tests it against the next line number, and queues matching objects in a small hit FIFO for the motion-object pixel renderer. It yields the RAM to the CPU whenever B2H is high and resumes without losing state.

---
 rtl/mob_pkg.sv | 39 +++
 rtl/mob_hit_fifo.sv | 73 +++++++
 rtl/mob_line_fetch.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mob_pkg.sv
`default_nettype none
// =============================================================================
// Module   : mob_pkg
// Purpose  : Shared constants, hit-entry layout and FSM encoding for the
//            motion-object line fetcher.
// Revision : 1.0 - initial release
// =============================================================================
package mob_pkg;

    localparam logic [2:0] MOB_BASE = 3'b111;

    localparam logic [1:0] OFS_VPOS = 2'd0;
    localparam logic [1:0] OFS_PIC  = 2'd1;
    localparam logic [1:0] OFS_COL  = 2'd2;
    localparam logic [1:0] OFS_XPOS = 2'd3;

    localparam int PIC_W  = 8;
    localparam int COL_W  = 3;
    localparam int XPOS_W = 8;
    localparam int ROW_W  = 4;
    localparam int HIT_W  = PIC_W + COL_W + XPOS_W + ROW_W;

    typedef struct packed {
        logic [PIC_W-1:0]  picture;
        logic [COL_W-1:0]  color;
        logic [XPOS_W-1:0] xpos;
        logic [ROW_W-1:0]  row;
    } hit_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_PUSH = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mob_hit_fifo.sv
`default_nettype none
// =============================================================================
// Module   : mob_hit_fifo
// Purpose  : First-word fall-through hit queue with synchronous flush.
// Revision : 1.0 - initial release
// =============================================================================
module mob_hit_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 23
) (
    input  logic             clk,
    input  logic             RESETn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_AW-1:0] c_LAST_PTR = c_AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_pop;
    logic             w_push;

    function automatic logic [c_AW-1:0] next_ptr(input logic [c_AW-1:0] ptr);
        return (ptr == c_LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign empty  = (r_count == '0);
    assign full   = (r_count == c_CW'(DEPTH));
    assign w_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full queue needs.
    assign w_push = push && (!full || w_pop);
    assign head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mob_line_fetch.sv
`default_nettype none
// =============================================================================
// Module   : mob_line_fetch
// Purpose  : Per-scanline motion-object descriptor walker feeding a hit queue.
// Revision : 1.0 - initial release
// =============================================================================
module mob_line_fetch #(
    parameter int NUM_OBJ  = 32,
    parameter int MAX_HITS = 8,
    parameter int OBJ_H    = 16
) (
    input  logic        clk,
    input  logic        RESETn,
    input  logic        hstart,
    input  logic [7:0]  vline,
    input  logic        buf_sel,
    input  logic        B2H,
    output logic [10:0] wram_addr,
    input  logic [7:0]  wram_data,
    output logic        hit_valid,
    output logic [22:0] hit_data,
    input  logic        hit_pop,
    output logic        scan_done,
    output logic        overflow
);

    import mob_pkg::*;

    localparam logic [4:0] c_LAST_OBJ = 5'(NUM_OBJ - 1);
    localparam int         c_ROW_SH   = $clog2(OBJ_H);

    state_t      r_state;
    logic [4:0]  r_obj;
    logic [1:0]  r_byte;
    logic        r_buf_sel_q;
    logic [7:0]  r_vline_q;
    hit_t        r_hit;
    logic        r_scan_done;
    logic        r_overflow;

    logic [7:0]  w_diff;
    logic        w_hit;
    logic        w_last;
    logic        w_push;
    logic        w_pop_req;
    logic        w_fifo_full;
    logic        w_fifo_empty;

    assign w_diff    = r_vline_q - wram_data;
    assign w_hit     = ((w_diff >> c_ROW_SH) == 8'd0);
    assign w_last    = (r_obj == c_LAST_OBJ);
    assign w_pop_req = hit_pop && hit_valid;
    assign w_push    = (r_state == ST_PUSH) && !hstart;

    assign wram_addr = {MOB_BASE, r_buf_sel_q, r_obj, r_byte};
    assign hit_valid = !w_fifo_empty;
    assign scan_done = r_scan_done;
    assign overflow  = r_overflow;

    mob_hit_fifo #(
        .DEPTH (MAX_HITS),
        .WIDTH (HIT_W)
    ) u_hit_fifo (
        .clk       (clk),
        .RESETn    (RESETn),
        .flush     (hstart),
        .push      (w_push),
        .push_data (r_hit),
        .pop       (hit_pop),
        .head      (hit_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            r_state     <= ST_IDLE;
            r_obj       <= '0;
            r_byte      <= '0;
            r_buf_sel_q <= 1'b0;
            r_vline_q   <= '0;
            r_hit       <= '0;
            r_scan_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (hstart) begin
            r_state     <= ST_RD;
            r_obj       <= '0;
            r_byte      <= '0;
            r_buf_sel_q <= buf_sel;
            r_vline_q   <= vline;
            r_scan_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_RD: begin
                    // While the CPU owns the RAM the same address is re-issued.
                    if (!B2H) begin
                        r_state <= ST_CAP;
                    end
                end
                ST_CAP: begin
                    case (r_byte)
                        OFS_VPOS: begin
                            if (w_hit) begin
                                r_hit.row <= w_diff[ROW_W-1:0];
                                r_byte    <= OFS_PIC;
                                r_state   <= ST_RD;
                            end else if (w_last) begin
                                r_state     <= ST_DONE;
                                r_scan_done <= 1'b1;
                            end else begin
                                r_obj   <= r_obj + 1'b1;
                                r_state <= ST_RD;
                            end
                        end
                        OFS_PIC: begin
                            r_hit.picture <= wram_data;
                            r_byte        <= OFS_COL;
                            r_state       <= ST_RD;
                        end
                        OFS_COL: begin
                            r_hit.color <= wram_data[COL_W-1:0];
                            r_byte      <= OFS_XPOS;
                            r_state     <= ST_RD;
                        end
                        default: begin
                            r_hit.xpos <= wram_data;
                            r_state    <= ST_PUSH;
                        end
                    endcase
                end
                ST_PUSH: begin
                    if (w_fifo_full && !w_pop_req) begin
                        r_overflow <= 1'b1;
                    end
                    r_byte <= OFS_VPOS;
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_scan_done <= 1'b1;
                    end else begin
                        r_obj   <= r_obj + 1'b1;
                        r_state <= ST_RD;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
